// File: rtl/a2fpga_pkg.sv
// Shared a2fpga definitions: bus arbiter FSM states and the lowest-set-bit helper
// used by the card bus arbiter and slotmaker.
package a2fpga_pkg;

    localparam int MAX_CARDS = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } arb_state_t;

    // Lowest set bit wins; an all-zero vector returns 0.
    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_CARDS-1:0] v);
        lowest_set_idx = '0;
        for (int i = MAX_CARDS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set_idx = MAX_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/prio_encoder.sv
// Combinational lowest-index priority encoder with a valid flag.
module prio_encoder
    import a2fpga_pkg::*;
#(
    parameter int NUM_CARDS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CARDS-1:0] req,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    logic [MAX_CARDS-1:0] req_pad;

    assign req_pad = MAX_CARDS'(req);
    assign idx     = IDX_W'(lowest_set_idx(req_pad));
    assign valid   = |req;

endmodule

// File: rtl/card_bus_arbiter.sv
// Non-preemptive fixed-priority read-bus arbiter for the virtual slot cards,
// plus the registered interrupt aggregation that replaces the board-level OR-trees.
module card_bus_arbiter
    import a2fpga_pkg::*;
#(
    parameter int NUM_CARDS  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    localparam int OWNER_W   = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic                            clk_logic,
    input  logic                            reset,
    input  logic [NUM_CARDS-1:0]            card_rd_en_i,
    input  logic [NUM_CARDS*DATA_WIDTH-1:0] card_data_i,
    input  logic [NUM_CARDS-1:0]            card_irq_n_i,
    input  logic [NUM_CARDS-1:0]            card_enable_i,
    input  logic [NUM_CARDS-1:0]            irq_mask_i,
    input  logic                            conflict_clr_i,
    output logic                            data_out_en_o,
    output logic [DATA_WIDTH-1:0]           data_out_o,
    output logic [OWNER_W-1:0]              owner_o,
    output logic                            irq_n_o,
    output logic [NUM_CARDS-1:0]            irq_pending_o,
    output logic [CNT_WIDTH-1:0]            conflict_count_o
);

    arb_state_t             state;
    logic [NUM_CARDS-1:0]   req;
    logic [NUM_CARDS-1:0]   irq_act;
    logic [OWNER_W-1:0]     enc_idx;
    logic                   enc_vld;
    logic [OWNER_W-1:0]     sel;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   contended;
    logic                   owner_held;

    assign req     = card_rd_en_i & card_enable_i;
    assign irq_act = ~card_irq_n_i & ~irq_mask_i & card_enable_i;

    prio_encoder #(
        .NUM_CARDS (NUM_CARDS),
        .IDX_W     (OWNER_W)
    ) u_prio_encoder (
        .req   (req),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    // In IDLE the winner's data is captured on the grant edge, so the bus
    // carries valid data in the same cycle data_out_en_o rises.
    assign sel        = (state == ST_IDLE) ? enc_idx : owner_o;
    assign sel_data   = card_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign contended  = |(req & (req - 1'b1));
    assign owner_held = req[owner_o];

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            state            <= ST_IDLE;
            data_out_en_o    <= 1'b0;
            data_out_o       <= '0;
            owner_o          <= '0;
            conflict_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_vld) begin
                        state         <= ST_DRIVE;
                        owner_o       <= enc_idx;
                        data_out_en_o <= 1'b1;
                        data_out_o    <= sel_data;
                    end else begin
                        data_out_en_o <= 1'b0;
                        data_out_o    <= '0;
                    end
                end
                ST_DRIVE: begin
                    // Release takes a full cycle; no re-arbitration until back in IDLE.
                    if (owner_held) begin
                        data_out_o <= sel_data;
                    end else begin
                        state         <= ST_IDLE;
                        data_out_en_o <= 1'b0;
                        data_out_o    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (conflict_clr_i)
                conflict_count_o <= '0;
            else if (state == ST_IDLE && enc_vld && contended && conflict_count_o != '1)
                conflict_count_o <= conflict_count_o + 1'b1;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            irq_pending_o <= '0;
            irq_n_o       <= 1'b1;
        end else begin
            irq_pending_o <= irq_act;
            irq_n_o       <= ~|irq_act;
        end
    end

endmodule
